line_fill_prefetch_buffer: RTL and testbench
============================================

// Module: line_fill_prefetch_buffer
// PURPOSE
// Read-side companion to the L2 eviction write buffer: services L2 line-fill reads (l2pmem_read) from pmem and
// runs a one-line next-line prefetch into a single 256-bit buffer. A demand read hitting the buffer returns
// without a pmem access. Snoops L2 writebacks so stale prefetched data is never returned. Yields pmem to the
// eviction write buffer whenever ewb_busy is high.
// PARAMETERS
// ADDR_WIDTH   32   byte address width
// LINE_WIDTH   256  line width in bits (32-byte line, 5 offset bits)
// PREFETCH_EN  1    1 = issue next-line prefetch after each demand fill or hit; 0 = pure pass-through
// PORTS
// clk             in   1           single clock; all state updates on posedge
// rst_n           in   1           reset: synchronous, active-low
// l2pmem_read     in   1           L2 demand line read; held high until l2pmem_resp
// l2pmem_write    in   1           L2 writeback of l2pmem_address (snoop only)
// l2pmem_address  in   ADDR_WIDTH  L2 line address (offset bits ignored)
// l2pmem_resp     out  1           one-cycle pulse: l2pmem_rdata valid, read complete
// l2pmem_rdata    out  LINE_WIDTH  line data returned to L2
// ewb_busy        in   1           eviction buffer owns pmem; no new pmem_read may start
// pmem_read       out  1           pmem read request; held until pmem_resp
// pmem_address    out  ADDR_WIDTH  line-aligned pmem address (low 5 bits zero)
// pmem_rdata      in   LINE_WIDTH  pmem read data, valid with pmem_resp
// pmem_resp       in   1           pmem read complete
// prefetch_hit    out  1           one-cycle pulse when a demand read is served from the buffer
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): state=IDLE, buf_valid=0, drop=0; l2pmem_resp=0, pmem_read=0, prefetch_hit=0,
//   pmem_address=0, l2pmem_rdata=0. Reset mid-transfer abandons it; a later stray pmem_resp in IDLE is ignored.
// - hit = l2pmem_read & buf_valid & (l2pmem_address[31:5]==buf_addr[31:5]).
// - FSM states IDLE, HIT, DEMAND, PREFETCH:
//   IDLE: hit -> HIT. l2pmem_read & !hit & !ewb_busy -> DEMAND. Otherwise stay.
//   HIT (1 cycle): l2pmem_resp=1, prefetch_hit=1, l2pmem_rdata=buf_data. Hit latency = 1 cycle after the request.
//     Next: PREFETCH of buf_addr+32 if PREFETCH_EN and no wrap, else IDLE.
//   DEMAND: pmem_read=1 at the aligned L2 address. On pmem_resp: l2pmem_resp=1 in the same cycle,
//     l2pmem_rdata=pmem_rdata (combinational pass-through). Next: PREFETCH of address+32 if PREFETCH_EN and
//     no wrap, else IDLE.
//   PREFETCH: entry clears buf_valid and loads buf_addr. If ewb_busy, pmem_read stays 0 until ewb_busy falls.
//     On pmem_resp: buf_data<=pmem_rdata, buf_valid<=!drop, drop<=0 -> IDLE.
// - After pmem_read is asserted it stays high, with pmem_address stable, until pmem_resp.
//   ewb_busy rising mid-request has no effect.
// - In-flight prefetch is never aborted. A demand read arriving in PREFETCH waits; on completion IDLE
//   re-evaluates it, so a matching address becomes a hit.
// - Write snoop: l2pmem_write with a line match to buf_addr clears buf_valid next cycle. If the match occurs
//   in PREFETCH, drop<=1 so the returning data is discarded. A snoop match and a demand hit in the same cycle:
//   the snoop wins and the read is treated as a miss.
// - Wrap: next-line address computed modulo 2^ADDR_WIDTH; if base is 0xFFFFFFE0 no prefetch is issued.
// - l2pmem_read and l2pmem_write are never both high (L2 guarantee); no checking required.
// STRUCTURE
// - Shared package cache_types_pkg: typedef logic [LINE_WIDTH-1:0] line_t; typedef logic [ADDR_WIDTH-1:0]
//   addr_t; enum fill_state_e {IDLE,HIT,DEMAND,PREFETCH}; localparam LINE_OFFSET_BITS=5.
// - Sub-module line_fill_prefetch_datapath: buf_data/buf_addr/buf_valid/drop registers, tag compare,
//   next-line adder. Top level holds the FSM and output muxing.
// TESTING
// 1 Reset: hold rst_n=0 for 2 cycles with pmem_resp=1 -> all outputs 0, no l2pmem_resp, buf_valid=0.
// 2 Cold read 0x1000_0040: pmem_read @0x1000_0040; pmem_resp with data D0 -> l2pmem_resp with D0 in the same cycle.
//   Then pmem_read @0x1000_0060; resp D1 -> buffer valid.
// 3 Read 0x1000_0064 (test 2 state): l2pmem_resp=1, prefetch_hit=1 next cycle, data D1, no demand pmem read.
//   Then prefetch @0x1000_0080.
// 4 Writeback snoop: l2pmem_write @0x1000_0080 during prefetch of 0x1000_0080 -> data dropped.
//   Then read 0x1000_0080 -> miss, new pmem_read.
// 5 Arbitration: ewb_busy=1 with read 0x2000_0000 -> pmem_read held 0. ewb_busy=0 -> pmem_read next cycle.
//   ewb_busy=1 mid-request -> pmem_read stays 1.
// 6 Wrap: read 0xFFFF_FFE0 -> demand served, no prefetch; state IDLE after resp; PREFETCH_EN=0 build never prefetches.

Source files
------------

// File: rtl/cache_types_pkg.sv
// Shared cache types for the L2 read-side line fill path.
// Line/address widths, state encoding and line offset size.
package cache_types_pkg;
   localparam int ADDR_WIDTH = 32;
   localparam int LINE_WIDTH = 256;
   localparam int LINE_OFFSET_BITS = 5;

   typedef logic [LINE_WIDTH-1:0] line_t;
   typedef logic [ADDR_WIDTH-1:0] addr_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HIT      = 2'd1,
      DEMAND   = 2'd2,
      PREFETCH = 2'd3
   } fill_state_e;
endpackage

// File: rtl/line_fill_prefetch_datapath.sv
// Prefetch buffer storage, tag compare, write snoop and
// next-line adder for the line fill prefetch buffer.
module line_fill_prefetch_datapath
   import cache_types_pkg::*;
#(
   parameter int TAG_WIDTH  = ADDR_WIDTH - LINE_OFFSET_BITS,
   parameter int LINE_WIDTH = cache_types_pkg::LINE_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  l2_read,
   input  logic                  l2_write,
   input  logic [TAG_WIDTH-1:0]  l2_tag,
   input  logic                  pf_start,
   input  logic [TAG_WIDTH-1:0]  pf_tag,
   input  logic                  in_prefetch,
   input  logic                  fill,
   input  logic [LINE_WIDTH-1:0] fill_data,
   input  logic [TAG_WIDTH-1:0]  base_tag,
   output logic [TAG_WIDTH-1:0]  next_tag,
   output logic                  wrap,
   output logic                  hit,
   output logic [TAG_WIDTH-1:0]  buf_tag,
   output logic [LINE_WIDTH-1:0] buf_data
);
   logic buf_valid;
   logic drop;
   logic snoop;

   assign snoop = l2_write & (l2_tag == buf_tag);
   // A snoop in the same cycle as a lookup wins
   assign hit = l2_read & buf_valid & (l2_tag == buf_tag) & ~snoop;
   assign next_tag = base_tag + 1'b1;
   assign wrap = &base_tag;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         buf_valid <= 1'b0;
         drop      <= 1'b0;
         buf_tag   <= '0;
      end else if (pf_start) begin
         buf_valid <= 1'b0;
         buf_tag   <= pf_tag;
         drop      <= l2_write & (l2_tag == pf_tag);
      end else if (fill) begin
         buf_valid <= ~(drop | snoop);
         drop      <= 1'b0;
      end else if (snoop) begin
         buf_valid <= 1'b0;
         drop      <= drop | in_prefetch;
      end
   end

   always_ff @(posedge clk) begin
      if (fill) buf_data <= fill_data;
   end
endmodule

// File: rtl/line_fill_prefetch_buffer.sv
// L2 line fill reader with a single-line next-line prefetch
// buffer; yields pmem to the eviction write buffer.
module line_fill_prefetch_buffer
   import cache_types_pkg::*;
#(
   parameter int ADDR_WIDTH  = cache_types_pkg::ADDR_WIDTH,
   parameter int LINE_WIDTH  = cache_types_pkg::LINE_WIDTH,
   parameter bit PREFETCH_EN = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  l2pmem_read,
   input  logic                  l2pmem_write,
   input  logic [ADDR_WIDTH-1:0] l2pmem_address,
   output logic                  l2pmem_resp,
   output logic [LINE_WIDTH-1:0] l2pmem_rdata,
   input  logic                  ewb_busy,
   output logic                  pmem_read,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp,
   output logic                  prefetch_hit
);
   localparam int TW = ADDR_WIDTH - LINE_OFFSET_BITS;

   fill_state_e state, state_nx;
   logic [TW-1:0] req_tag, req_tag_nx;
   logic [TW-1:0] l2_tag, buf_tag, base_tag, next_tag;
   logic [LINE_WIDTH-1:0] buf_data;
   logic issued, hit, wrap, pf_go, pf_start;
   logic in_pf, fill, done;
   logic unused_offset;

   assign l2_tag = l2pmem_address[ADDR_WIDTH-1:LINE_OFFSET_BITS];
   assign unused_offset = ^l2pmem_address[LINE_OFFSET_BITS-1:0];

   assign in_pf = (state == PREFETCH);
   assign base_tag = (state == HIT) ? buf_tag : req_tag;
   assign pf_go = PREFETCH_EN & ~wrap;

   // Once issued, a prefetch request ignores ewb_busy
   assign pmem_read = (state == DEMAND)
                    | (in_pf & (issued | ~ewb_busy));
   assign fill = in_pf & pmem_read & pmem_resp;
   assign done = (state == DEMAND) & pmem_resp;
   assign l2pmem_resp = (state == HIT) | done;
   assign prefetch_hit = (state == HIT);
   assign pmem_address = {req_tag, {LINE_OFFSET_BITS{1'b0}}};

   always_comb begin
      l2pmem_rdata = '0;
      unique case (1'b1)
         state == HIT: l2pmem_rdata = buf_data;
         done:         l2pmem_rdata = pmem_rdata;
         default:      l2pmem_rdata = '0;
      endcase
   end

   always_comb begin
      state_nx   = state;
      req_tag_nx = req_tag;
      pf_start   = 1'b0;
      unique case (state)
         IDLE: begin
            if (hit) begin
               state_nx = HIT;
            end else if (l2pmem_read && !ewb_busy) begin
               state_nx   = DEMAND;
               req_tag_nx = l2_tag;
            end
         end
         HIT, DEMAND: begin
            if (state == HIT || pmem_resp) begin
               if (pf_go) begin
                  state_nx   = PREFETCH;
                  req_tag_nx = next_tag;
                  pf_start   = 1'b1;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         PREFETCH: begin
            if (fill) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         req_tag <= '0;
         issued  <= 1'b0;
      end else begin
         state   <= state_nx;
         req_tag <= req_tag_nx;
         issued  <= in_pf & pmem_read & ~pmem_resp;
      end
   end

   line_fill_prefetch_datapath #(
      .TAG_WIDTH (TW),
      .LINE_WIDTH(LINE_WIDTH)
   ) u_dp (
      .clk        (clk),
      .rst_n      (rst_n),
      .l2_read    (l2pmem_read),
      .l2_write   (l2pmem_write),
      .l2_tag     (l2_tag),
      .pf_start   (pf_start),
      .pf_tag     (next_tag),
      .in_prefetch(in_pf),
      .fill       (fill),
      .fill_data  (pmem_rdata),
      .base_tag   (base_tag),
      .next_tag   (next_tag),
      .wrap       (wrap),
      .hit        (hit),
      .buf_tag    (buf_tag),
      .buf_data   (buf_data)
   );
endmodule

// File: tb/tb_line_fill_prefetch_buffer.sv
// Scoreboard bench for line_fill_prefetch_buffer: demand fills,
// hits, snoop drops, ewb arbitration, wrap and no-prefetch build.
module tb_line_fill_prefetch_buffer;
   import cache_types_pkg::*;

   logic  clk = 1'b0;
   logic  rst_n = 1'b0;
   logic  l2_read = 1'b0, l2_write = 1'b0;
   addr_t l2_addr = '0;
   logic  ewb = 1'b0;
   line_t p_rdata = '0;
   logic  p_resp = 1'b0;
   logic  l2_resp, p_read, phit;
   line_t l2_rdata;
   addr_t p_addr;

   logic  n_read = 1'b0, n_write = 1'b0, n_resp = 1'b0;
   addr_t n_addr = '0;
   line_t n_rdata = '0;
   logic  n_l2resp, n_pread, n_phit;
   line_t n_l2rdata;
   addr_t n_paddr;

   int total = 0;
   int bad = 0;
   line_t exp_q[$];

   always #5 clk = ~clk;

   line_fill_prefetch_buffer dut (
      .clk(clk), .rst_n(rst_n),
      .l2pmem_read(l2_read), .l2pmem_write(l2_write),
      .l2pmem_address(l2_addr), .l2pmem_resp(l2_resp),
      .l2pmem_rdata(l2_rdata), .ewb_busy(ewb),
      .pmem_read(p_read), .pmem_address(p_addr),
      .pmem_rdata(p_rdata), .pmem_resp(p_resp),
      .prefetch_hit(phit)
   );

   line_fill_prefetch_buffer #(.PREFETCH_EN(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .l2pmem_read(n_read), .l2pmem_write(n_write),
      .l2pmem_address(n_addr), .l2pmem_resp(n_l2resp),
      .l2pmem_rdata(n_l2rdata), .ewb_busy(ewb),
      .pmem_read(n_pread), .pmem_address(n_paddr),
      .pmem_rdata(n_rdata), .pmem_resp(n_resp),
      .prefetch_hit(n_phit)
   );

   function automatic line_t mk(input int n);
      return {8{32'hA5A5_0000 ^ (32'(n) * 32'h0101_0003)}};
   endfunction

   always @(negedge clk) begin
      if (rst_n && l2_resp) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL l2_resp_unexpected got data=%h", l2_rdata[31:0]);
         end else begin
            line_t e;
            e = exp_q.pop_front();
            if (l2_rdata !== e) begin
               bad++;
               $display("FAIL l2_rdata got=%h exp=%h",
                        l2_rdata[31:0], e[31:0]);
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   // Wait for a pmem read at addr a, answer with d
   task automatic serve(input addr_t a, input line_t d, input bit demand);
      int i;
      for (i = 0; i < 20 && !p_read; i++) tick();
      total++;
      if (!p_read) begin
         bad++;
         $display("FAIL pmem_read_timeout got=0 exp=1 addr=%h", a);
      end else begin
         chk("pmem_address", p_addr, a);
         p_rdata = d;
         p_resp = 1'b1;
         if (demand) exp_q.push_back(d);
         tick();
         p_resp = 1'b0;
         if (demand) l2_read = 1'b0;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      p_resp = 1'b1;
      p_rdata = mk(99);
      tick();
      tick();
      chk("rst_l2_resp", 32'(l2_resp), 0);
      chk("rst_pmem_read", 32'(p_read), 0);
      chk("rst_prefetch_hit", 32'(phit), 0);
      chk("rst_pmem_address", p_addr, 0);
      chk("rst_l2_rdata", 32'(|l2_rdata), 0);
      chk("rst_np_l2_resp", 32'(n_l2resp), 0);
      rst_n = 1'b1;
      tick();
      chk("stray_resp_l2_resp", 32'(l2_resp), 0);
      chk("stray_resp_pmem_read", 32'(p_read), 0);
      p_resp = 1'b0;
   endtask

   task automatic test_cold_read;
      l2_addr = 32'h1000_0040;
      l2_read = 1'b1;
      serve(32'h1000_0040, mk(0), 1'b1);
      serve(32'h1000_0060, mk(1), 1'b0);
   endtask

   task automatic test_hit;
      l2_addr = 32'h1000_0064;
      l2_read = 1'b1;
      exp_q.push_back(mk(1));
      tick();
      chk("hit_l2_resp", 32'(l2_resp), 1);
      chk("hit_prefetch_hit", 32'(phit), 1);
      chk("hit_no_pmem_read", 32'(p_read), 0);
      l2_read = 1'b0;
      tick();
      chk("hit_next_pf_read", 32'(p_read), 1);
      chk("hit_next_pf_addr", p_addr, 32'h1000_0080);
   endtask

   task automatic test_snoop_drop;
      l2_write = 1'b1;
      l2_addr = 32'h1000_0088;
      tick();
      l2_write = 1'b0;
      serve(32'h1000_0080, mk(2), 1'b0);
      l2_addr = 32'h1000_0080;
      l2_read = 1'b1;
      serve(32'h1000_0080, mk(3), 1'b1);
      serve(32'h1000_00A0, mk(4), 1'b0);
      // snoop of a valid line while idle
      l2_write = 1'b1;
      l2_addr = 32'h1000_00A0;
      tick();
      l2_write = 1'b0;
      l2_addr = 32'h1000_00A4;
      l2_read = 1'b1;
      serve(32'h1000_00A0, mk(5), 1'b1);
      serve(32'h1000_00C0, mk(6), 1'b0);
   endtask

   task automatic test_arbitration;
      ewb = 1'b1;
      l2_addr = 32'h2000_0000;
      l2_read = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ewb_hold_read", 32'(p_read), 0);
      end
      ewb = 1'b0;
      tick();
      chk("ewb_release_read", 32'(p_read), 1);
      ewb = 1'b1;
      tick();
      chk("ewb_mid_read", 32'(p_read), 1);
      chk("ewb_mid_addr", p_addr, 32'h2000_0000);
      serve(32'h2000_0000, mk(7), 1'b1);
      chk("ewb_pf_hold0", 32'(p_read), 0);
      tick();
      chk("ewb_pf_hold1", 32'(p_read), 0);
      ewb = 1'b0;
      #1;
      chk("ewb_pf_go", 32'(p_read), 1);
      serve(32'h2000_0020, mk(8), 1'b0);
   endtask

   task automatic test_back_to_back;
      l2_addr = 32'h3000_0000;
      l2_read = 1'b1;
      serve(32'h3000_0000, mk(9), 1'b1);
      chk("b2b_pf_read", 32'(p_read), 1);
      l2_addr = 32'h3000_0024;
      l2_read = 1'b1;
      exp_q.push_back(mk(10));
      serve(32'h3000_0020, mk(10), 1'b0);
      tick();
      chk("b2b_prefetch_hit", 32'(phit), 1);
      l2_read = 1'b0;
      tick();
      serve(32'h3000_0040, mk(11), 1'b0);
   endtask

   task automatic test_wrap;
      l2_addr = 32'hFFFF_FFE0;
      l2_read = 1'b1;
      serve(32'hFFFF_FFE0, mk(12), 1'b1);
      for (int i = 0; i < 3; i++) begin
         chk("wrap_no_pf", 32'(p_read), 0);
         tick();
      end
      chk("wrap_idle_resp", 32'(l2_resp), 0);
   endtask

   task automatic test_no_prefetch;
      n_addr = 32'h4000_0010;
      n_read = 1'b1;
      tick();
      chk("np_pmem_read", 32'(n_pread), 1);
      chk("np_pmem_addr", n_paddr, 32'h4000_0000);
      n_rdata = mk(13);
      n_resp = 1'b1;
      #1;
      chk("np_l2_resp", 32'(n_l2resp), 1);
      chk("np_l2_rdata", n_l2rdata[31:0], mk(13) & 32'hFFFF_FFFF);
      tick();
      n_resp = 1'b0;
      n_read = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("np_no_pf", 32'(n_pread), 0);
         tick();
      end
      n_addr = 32'h4000_0020;
      n_read = 1'b1;
      tick();
      chk("np_miss_hit", 32'(n_phit), 0);
      chk("np_miss_read", 32'(n_pread), 1);
      n_resp = 1'b1;
      tick();
      n_resp = 1'b0;
      n_read = 1'b0;
   endtask

   initial begin
      test_reset();
      test_cold_read();
      test_hit();
      test_snoop_drop();
      test_arbitration();
      test_back_to_back();
      test_wrap();
      test_no_prefetch();
      tick();
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
